hist_peak_finder: RTL and testbench

- Downstream stage of the SiFH histogram builder.
- After the builder has filled the histogram RAM, this block scans each pixel's histogram through the RAM read port and finds the bin with the maximum count.
- It emits one peak result (pixel, bin, count) per pixel, then signals done.
- It owns RAM port B (read) and, with the optional feature, RAM port A (write) during the scan.

---
 rtl/hist_peak_finder_if.sv | 34 +++
 rtl/hist_peak_finder.sv | 126 ++++++++++++
 tb/tb_hist_peak_finder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hist_peak_finder_if.sv
// rtl/hist_peak_finder_if.sv - Histogram RAM ports, start handshake and peak result bundle for hist_peak_finder.
// master is the peak finder side; slave is the builder/RAM side.
interface hist_peak_finder_if #(
  parameter int NB     = 6,
  parameter int PIX_W  = 2,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_data;
  logic              busy;
  logic              peak_valid;
  logic [PIX_W-1:0]  peak_pixel;
  logic [NB-1:0]     peak_bin;
  logic [CNT_W-1:0]  peak_count;
  logic              done;

  modport master (
    input  start, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output busy, peak_valid, peak_pixel, peak_bin, peak_count, done
  );

  modport slave (
    output start, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  busy, peak_valid, peak_pixel, peak_bin, peak_count, done
  );
endinterface

// File: rtl/hist_peak_finder.sv
// rtl/hist_peak_finder.sv - Scans each pixel's histogram in RAM and reports the peak bin per pixel.
// Optional macro SIFH_PEAK_CLEAR_ON_READ_EN zeroes every bin through RAM port A right after it is read.
module hist_peak_finder #(
  parameter int BIN_NUM   = 64,
  parameter int NB        = 6,
  parameter int PIXEL_NUM = 4,
  parameter int PIX_W     = 2,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 8
) (
  input logic                clk,
  input logic                res,
  hist_peak_finder_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] EMIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [NB-1:0]    BIN_LAST = NB'(BIN_NUM - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_NUM - 1);

  logic [2:0]       state;
  logic [PIX_W-1:0] pixel;
  logic [NB-1:0]    bin;
  logic             rd_en_d;
  logic [NB-1:0]    bin_d;
  logic [CNT_W-1:0] max_cnt;
  logic [NB-1:0]    max_bin;
  logic [PIX_W-1:0] peak_pixel_r;
  logic [NB-1:0]    peak_bin_r;
  logic [CNT_W-1:0] peak_count_r;

  logic             take;
  logic [CNT_W-1:0] cmp_max;
  logic [NB-1:0]    cmp_bin;

  // Bin 0 always seeds the running max; later bins need a strict win so ties keep the lowest bin.
  always_comb begin
    take    = rd_en_d && ((bin_d == '0) || (bus.rd_data > max_cnt));
    cmp_max = take ? bus.rd_data : max_cnt;
    cmp_bin = take ? bin_d : max_bin;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state        <= IDLE;
      pixel        <= '0;
      bin          <= '0;
      rd_en_d      <= 1'b0;
      bin_d        <= '0;
      max_cnt      <= '0;
      max_bin      <= '0;
      peak_pixel_r <= '0;
      peak_bin_r   <= '0;
      peak_count_r <= '0;
    end else begin
      rd_en_d <= (state == SCAN);
      bin_d   <= bin;
      if (rd_en_d) begin
        max_cnt <= cmp_max;
        max_bin <= cmp_bin;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            pixel <= '0;
            bin   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          bin <= bin + 1'b1;
          if (bin == BIN_LAST) state <= DRAIN;
        end
        DRAIN: begin
          // Final bin's data arrives now, so the result is latched straight from the compare.
          peak_pixel_r <= pixel;
          peak_bin_r   <= cmp_bin;
          peak_count_r <= cmp_max;
          state        <= EMIT;
        end
        EMIT: begin
          if (pixel != PIX_LAST) begin
            pixel <= pixel + 1'b1;
            bin   <= '0;
            state <= SCAN;
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_en      = (state == SCAN);
  assign bus.rd_addr    = (state == SCAN) ? ADDR_W'({pixel, bin}) : '0;
  assign bus.busy       = (state == SCAN) || (state == DRAIN) || (state == EMIT);
  assign bus.peak_valid = (state == EMIT);
  assign bus.done       = (state == DONE);
  assign bus.peak_pixel = peak_pixel_r;
  assign bus.peak_bin   = peak_bin_r;
  assign bus.peak_count = peak_count_r;

`ifdef SIFH_PEAK_CLEAR_ON_READ_EN
  logic [ADDR_W-1:0] rd_addr_d;

  always_ff @(posedge clk or negedge res) begin
    if (!res) rd_addr_d <= '0;
    else      rd_addr_d <= bus.rd_addr;
  end

  assign bus.wr_en   = rd_en_d;
  assign bus.wr_addr = rd_en_d ? rd_addr_d : '0;
  assign bus.wr_data = '0;
`else
  assign bus.wr_en   = 1'b0;
  assign bus.wr_addr = '0;
  assign bus.wr_data = '0;
`endif

endmodule

// File: tb/tb_hist_peak_finder.sv
// tb/tb_hist_peak_finder.sv - Self-checking bench for hist_peak_finder with a RAM model and argmax reference.
module tb_hist_peak_finder;

  localparam int BIN_NUM = 64, NB = 6, PIXEL_NUM = 4, PIX_W = 2, CNT_W = 8, ADDR_W = 8;
  localparam int WORDS = BIN_NUM * PIXEL_NUM;

  typedef struct {
    int pix;
    int bin;
    int cnt;
    int cyc;
  } pk_t;

  logic clk = 1'b0;
  logic res = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  hist_peak_finder_if #(.NB(NB), .PIX_W(PIX_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  hist_peak_finder #(
    .BIN_NUM(BIN_NUM), .NB(NB), .PIXEL_NUM(PIXEL_NUM),
    .PIX_W(PIX_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CNT_W-1:0] img [WORDS];
  logic [CNT_W-1:0] ram [WORDS];
  logic             load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= img[i];
    end else begin
      if (bus.rd_en === 1'b1) bus.rd_data <= ram[bus.rd_addr];
      if (bus.wr_en === 1'b1) ram[bus.wr_addr] <= bus.wr_data;
    end
  end

  pk_t  pk_q[$];
  int   dn_q[$];
  int   rd_cnt = 0;
  int   wr_seen = 0;
  int   trail_err = 0;
  logic prv_rd_en = 1'b0;
  logic [ADDR_W-1:0] prv_rd_addr = '0;

  always @(negedge clk) begin
    if (!res) begin
      prv_rd_en   <= 1'b0;
      prv_rd_addr <= '0;
    end else begin
      if (bus.peak_valid === 1'b1)
        pk_q.push_back('{int'(bus.peak_pixel), int'(bus.peak_bin), int'(bus.peak_count), cyc});
      if (bus.done === 1'b1) dn_q.push_back(cyc);
      if (bus.rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
      if (bus.wr_en === 1'b1) wr_seen <= wr_seen + 1;
`ifdef SIFH_PEAK_CLEAR_ON_READ_EN
      if (bus.wr_en !== prv_rd_en ||
          (prv_rd_en && (bus.wr_addr !== prv_rd_addr || bus.wr_data !== '0)))
        trail_err <= trail_err + 1;
`endif
      prv_rd_en   <= bus.rd_en;
      prv_rd_addr <= bus.rd_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_peak_valid"}, bus.peak_valid, 0);
    chk({tag, "_peak_pixel"}, bus.peak_pixel, 0);
    chk({tag, "_peak_bin"}, bus.peak_bin, 0);
    chk({tag, "_peak_count"}, bus.peak_count, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  task automatic load_ram();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_pass(input string tag, input bit repulse);
    int base_pk, base_dn, base_rd, base_wr, base_tr, c0, t, bad;
    int exp_bin[PIXEL_NUM];
    int exp_cnt[PIXEL_NUM];
    pk_t r;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      exp_bin[p] = 0;
      exp_cnt[p] = img[p*BIN_NUM];
      for (int b = 1; b < BIN_NUM; b++) begin
        if (int'(img[p*BIN_NUM+b]) > exp_cnt[p]) begin
          exp_cnt[p] = img[p*BIN_NUM+b];
          exp_bin[p] = b;
        end
      end
    end
    load_ram();
    base_pk = pk_q.size(); base_dn = dn_q.size();
    base_rd = rd_cnt; base_wr = wr_seen; base_tr = trail_err;
    @(negedge clk);
    bus.start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy_after_start"}, bus.busy, 1);
    t = 0;
    while (dn_q.size() == base_dn && t < 600) begin
      @(negedge clk);
      t++;
      bus.start = (repulse && (t == 100 || t == 200)) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, (t < 600), 1);
    repeat (5) @(negedge clk);
    chk({tag, "_peak_valid_count"}, pk_q.size() - base_pk, PIXEL_NUM);
    chk({tag, "_done_count"}, dn_q.size() - base_dn, 1);
    chk({tag, "_rd_count"}, rd_cnt - base_rd, WORDS);
    chk({tag, "_busy_end"}, bus.busy, 0);
    for (int p = 0; p < PIXEL_NUM; p++) begin
      if (base_pk + p < pk_q.size()) begin
        r = pk_q[base_pk + p];
        chk($sformatf("%s_p%0d_pixel", tag, p), r.pix, p);
        chk($sformatf("%s_p%0d_bin", tag, p), r.bin, exp_bin[p]);
        chk($sformatf("%s_p%0d_count", tag, p), r.cnt, exp_cnt[p]);
        chk($sformatf("%s_p%0d_latency", tag, p), r.cyc - c0, (p + 1) * (BIN_NUM + 2));
      end
    end
    if (base_dn < dn_q.size())
      chk({tag, "_done_latency"}, dn_q[base_dn] - c0, PIXEL_NUM * (BIN_NUM + 2) + 1);
    bad = 0;
`ifdef SIFH_PEAK_CLEAR_ON_READ_EN
    for (int i = 0; i < WORDS; i++) if (ram[i] !== '0) bad++;
    chk({tag, "_ram_nonzero_words"}, bad, 0);
    chk({tag, "_wr_trail_errors"}, trail_err - base_tr, 0);
    chk({tag, "_wr_count"}, wr_seen - base_wr, WORDS);
`else
    for (int i = 0; i < WORDS; i++) if (ram[i] !== img[i]) bad++;
    chk({tag, "_ram_changed_words"}, bad, 0);
    chk({tag, "_wr_en_seen"}, wr_seen - base_wr, 0);
    chk({tag, "_trail_unused"}, trail_err - base_tr, 0);
`endif
  endtask

  initial begin
    int t, base_pk, mode;
    bus.start   = 1'b0;
    bus.rd_data = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    res = 1'b1;

    for (int b = 0; b < BIN_NUM; b++) begin
      img[b]              = CNT_W'($urandom_range(0, 36));
      img[BIN_NUM+b]      = CNT_W'($urandom_range(0, 199));
      img[2*BIN_NUM+b]    = '0;
      img[3*BIN_NUM+b]    = CNT_W'($urandom_range(0, 254));
    end
    img[10]           = 8'd37;
    img[BIN_NUM+5]    = 8'd200;
    img[BIN_NUM+40]   = 8'd200;
    img[3*BIN_NUM+63] = 8'd255;
    load_ram();

    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (!(bus.rd_en === 1'b1 && bus.rd_addr === 8'd2) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_bin2", (t < 20), 1);
    base_pk = pk_q.size();
    #1 res = 1'b0;
    #1 chk_zero("abort_async");
    @(posedge clk);
    @(negedge clk);
    chk_zero("abort_next");
    chk("abort_no_peak", pk_q.size() - base_pk, 0);
    res = 1'b1;

    run_pass("directed", 1'b1);

    for (int it = 0; it < 3; it++) begin
      for (int p = 0; p < PIXEL_NUM; p++) begin
        mode = $urandom_range(0, 2);
        for (int b = 0; b < BIN_NUM; b++) begin
          case (mode)
            0:       img[p*BIN_NUM+b] = CNT_W'($urandom_range(0, 255));
            1:       img[p*BIN_NUM+b] = CNT_W'($urandom_range(0, 3));
            default: img[p*BIN_NUM+b] = 8'd255;
          endcase
        end
      end
      run_pass($sformatf("rand%0d", it), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
